// File: rtl/ascii_cmd_parser_if.sv
// Bundle of the RX-FIFO side and command side of the ASCII command parser.
// The parser uses the master view; the FIFO/ALU environment uses the slave view.
interface ascii_cmd_parser_if #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 6
);
  // RX FIFO side (show-ahead head byte)
  logic              FIFO_EMPTY;
  logic [7:0]        RX_DATA;
  logic              RD_FIFO;

  // Command side towards the ALU handler
  logic [DATA_W-1:0] OP_A;
  logic [DATA_W-1:0] OP_B;
  logic [OPC_W-1:0]  OPCODE;
  logic              CMD_VALID;
  logic              CMD_READY;

  // Error reporting and debug
  logic              ERR;
  logic [1:0]        ERR_CODE;
  logic [2:0]        STATE;

  modport master (
    input  FIFO_EMPTY, RX_DATA, CMD_READY,
    output RD_FIFO, OP_A, OP_B, OPCODE, CMD_VALID, ERR, ERR_CODE, STATE
  );

  modport slave (
    output FIFO_EMPTY, RX_DATA, CMD_READY,
    input  RD_FIFO, OP_A, OP_B, OPCODE, CMD_VALID, ERR, ERR_CODE, STATE
  );
endinterface

// File: rtl/ascii_cmd_parser.sv
// ASCII command parser: reads "<A><op><B>CR" lines from the RX FIFO, one
// character per cycle, and presents a complete ALU command with valid/ready.
// Malformed lines raise a one-cycle ERR pulse and are discarded up to CR.
module ascii_cmd_parser #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3,
  parameter int OPC_W      = 6
) (
  input logic               CLK,
  input logic               RESET,
  ascii_cmd_parser_if.master bus
);

  localparam int ACC_W = DATA_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    A_DIG = 3'd0,
    B_DIG = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3
  } state_t;

  localparam logic [1:0] ERR_BAD      = 2'd0;
  localparam logic [1:0] ERR_TOO_LONG = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_SYNTAX   = 2'd3;

  // Registered state
  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [OPC_W-1:0]  r_opcode;
  logic              r_cmd_valid;
  logic              r_err;
  logic [1:0]        r_err_code;

  // Next-state values
  state_t            w_nxt_state;
  logic [DATA_W-1:0] w_nxt_acc;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [DATA_W-1:0] w_nxt_op_a;
  logic [DATA_W-1:0] w_nxt_op_b;
  logic [OPC_W-1:0]  w_nxt_opcode;
  logic              w_nxt_cmd_valid;
  logic [1:0]        w_nxt_err_code;

  // Character decode and arithmetic
  logic              w_rd;
  logic              w_is_digit;
  logic              w_is_cr;
  logic              w_is_ign;
  logic              w_is_op;
  logic [OPC_W-1:0]  w_op_map;
  logic [3:0]        w_digit;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_ovf;
  logic              w_too_long;
  logic              w_fire;
  logic [1:0]        w_fire_code;

  // Pop the head byte whenever a reading state sees data; never during reset.
  assign w_rd = RESET && !bus.FIFO_EMPTY &&
                ((r_state == A_DIG) || (r_state == B_DIG) || (r_state == FLUSH));

  assign w_digit    = bus.RX_DATA[3:0];
  assign w_acc_next = ACC_W'(r_acc) * ACC_W'(10) + ACC_W'(w_digit);
  assign w_ovf      = (w_acc_next[ACC_W-1:DATA_W] != '0);
  assign w_too_long = (r_cnt == CNT_W'(MAX_DIGITS));

  // Classify the head byte and map operator characters to ALU funct codes.
  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_is_digit = (bus.RX_DATA >= 8'h30) && (bus.RX_DATA <= 8'h39);
    w_is_cr    = (bus.RX_DATA == 8'h0D);
    w_is_ign   = (bus.RX_DATA == 8'h20) || (bus.RX_DATA == 8'h0A);
    w_is_op    = 1'b1;
    w_op_map   = '0;
    case (bus.RX_DATA)
      8'h2B:   w_op_map = OPC_W'(6'b100000);  // '+'
      8'h2D:   w_op_map = OPC_W'(6'b100010);  // '-'
      8'h26:   w_op_map = OPC_W'(6'b100100);  // '&'
      8'h7C:   w_op_map = OPC_W'(6'b100101);  // '|'
      8'h5E:   w_op_map = OPC_W'(6'b100110);  // '^'
      8'h7E:   w_op_map = OPC_W'(6'b100111);  // '~'
      8'h3E:   w_op_map = OPC_W'(6'b000010);  // '>' SRL
      8'h5D:   w_op_map = OPC_W'(6'b000011);  // ']' SRA
      default: w_is_op  = 1'b0;
    endcase
  end

  // Next-state and datapath decisions for the parser FSM.
  // NOTE: combinational blocks use blocking '=' so later lines see earlier
  // results; the clocked block below uses non-blocking '<=' only.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_acc       = r_acc;
    w_nxt_cnt       = r_cnt;
    w_nxt_op_a      = r_op_a;
    w_nxt_op_b      = r_op_b;
    w_nxt_opcode    = r_opcode;
    w_nxt_cmd_valid = r_cmd_valid;
    w_nxt_err_code  = r_err_code;
    w_fire          = 1'b0;
    w_fire_code     = ERR_BAD;

    case (r_state)
      A_DIG: begin
        if (w_rd) begin
          if (w_is_ign) begin
            // space / LF: consumed, no effect
          end else if (w_is_digit) begin
            if (w_too_long) begin
              w_fire      = 1'b1;
              w_fire_code = ERR_TOO_LONG;
            end else if (w_ovf) begin
              w_fire      = 1'b1;
              w_fire_code = ERR_OVERFLOW;
            end else begin
              w_nxt_acc = w_acc_next[DATA_W-1:0];
              w_nxt_cnt = r_cnt + CNT_W'(1);
            end
          end else if (w_is_op) begin
            if (r_cnt != '0) begin
              w_nxt_op_a   = r_acc;
              w_nxt_opcode = w_op_map;
              w_nxt_acc    = '0;
              w_nxt_cnt    = '0;
              w_nxt_state  = B_DIG;
            end else begin
              w_fire      = 1'b1;
              w_fire_code = ERR_SYNTAX;
            end
          end else if (w_is_cr) begin
            // An empty line is silently skipped; a lone first operand is not.
            if (r_cnt != '0) begin
              w_fire      = 1'b1;
              w_fire_code = ERR_SYNTAX;
            end
          end else begin
            w_fire      = 1'b1;
            w_fire_code = ERR_BAD;
          end
        end
      end

      B_DIG: begin
        if (w_rd) begin
          if (w_is_ign) begin
            // space / LF: consumed, no effect
          end else if (w_is_digit) begin
            if (w_too_long) begin
              w_fire      = 1'b1;
              w_fire_code = ERR_TOO_LONG;
            end else if (w_ovf) begin
              w_fire      = 1'b1;
              w_fire_code = ERR_OVERFLOW;
            end else begin
              w_nxt_acc = w_acc_next[DATA_W-1:0];
              w_nxt_cnt = r_cnt + CNT_W'(1);
            end
          end else if (w_is_cr) begin
            if (r_cnt != '0) begin
              w_nxt_op_b      = r_acc;
              w_nxt_acc       = '0;
              w_nxt_cnt       = '0;
              w_nxt_cmd_valid = 1'b1;
              w_nxt_state     = HOLD;
            end else begin
              w_fire      = 1'b1;
              w_fire_code = ERR_SYNTAX;
            end
          end else begin
            // A second operator is as malformed as any unknown character.
            w_fire      = 1'b1;
            w_fire_code = ERR_BAD;
          end
        end
      end

      HOLD: begin
        if (r_cmd_valid && bus.CMD_READY) begin
          w_nxt_cmd_valid = 1'b0;
          w_nxt_state     = A_DIG;
        end
      end

      FLUSH: begin
        if (w_rd && w_is_cr) begin
          w_nxt_state = A_DIG;
        end
      end

      default: begin
        w_nxt_state = A_DIG;
      end
    endcase

    // Any parse error drops the partial line; a CR offender already ended it.
    if (w_fire) begin
      w_nxt_acc      = '0;
      w_nxt_cnt      = '0;
      w_nxt_err_code = w_fire_code;
      w_nxt_state    = w_is_cr ? A_DIG : FLUSH;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= A_DIG;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_opcode    <= '0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_acc       <= w_nxt_acc;
      r_cnt       <= w_nxt_cnt;
      r_op_a      <= w_nxt_op_a;
      r_op_b      <= w_nxt_op_b;
      r_opcode    <= w_nxt_opcode;
      r_cmd_valid <= w_nxt_cmd_valid;
      r_err       <= w_fire;
      r_err_code  <= w_nxt_err_code;
    end
  end

  assign bus.RD_FIFO   = w_rd;
  assign bus.OP_A      = r_op_a;
  assign bus.OP_B      = r_op_b;
  assign bus.OPCODE    = r_opcode;
  assign bus.CMD_VALID = r_cmd_valid;
  assign bus.ERR       = r_err;
  assign bus.ERR_CODE  = r_err_code;
  assign bus.STATE     = r_state;

endmodule

// File: tb/tb_ascii_cmd_parser.sv
// Bench for ascii_cmd_parser: a byte-queue RX FIFO model feeds the parser,
// expected commands and error codes go to scoreboard queues as lines are sent,
// and a negedge monitor pops and compares them as the parser reports.
module tb_ascii_cmd_parser;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  always #5 CLK = ~CLK;

  ascii_cmd_parser_if #(.DATA_W(8), .OPC_W(6)) bus ();

  ascii_cmd_parser #(.DATA_W(8), .MAX_DIGITS(3), .OPC_W(6)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [1:0] err_q[$];
  logic [7:0] fifo[$];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   rd_count  = 0;
  logic tb_pop    = 1'b0;
  logic prev_vld  = 1'b0;

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
  endtask

  task automatic send_line(input string s);
    send(s);
    push_byte(8'h0D);
  endtask

  task automatic expect_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    cmd_t c;
    c.a  = a;
    c.b  = b;
    c.op = op;
    cmd_q.push_back(c);
  endtask

  // Wait until every sent byte is consumed and every expectation reported.
  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (fifo.size() == 0 && bus.FIFO_EMPTY === 1'b1 && cmd_q.size() == 0 &&
          err_q.size() == 0 && bus.CMD_VALID === 1'b0 && bus.STATE === 3'd0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle: not idle after 300 cycles (fifo=%0d cmds=%0d errs=%0d STATE=%0d), required all drained in STATE 0",
               name, fifo.size(), cmd_q.size(), err_q.size(), bus.STATE);
      fifo.delete();
      cmd_q.delete();
      err_q.delete();
    end
  endtask

  // ---------------- FIFO model ----------------
  task automatic pop_loop();
    forever begin
      @(posedge CLK);
      tb_pop = bus.RD_FIFO;
      if (bus.RD_FIFO === 1'b1) rd_count++;
    end
  endtask

  task automatic fifo_loop();
    forever begin
      @(negedge CLK);
      if (tb_pop === 1'b1 && fifo.size() != 0) void'(fifo.pop_front());
      tb_pop         = 1'b0;
      bus.FIFO_EMPTY = (fifo.size() == 0);
      bus.RX_DATA    = (fifo.size() == 0) ? 8'h00 : fifo[0];
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor();
    cmd_t       c;
    logic [1:0] e;
    forever begin
      @(negedge CLK);
      if (bus.ERR === 1'b1) begin
        n_checks++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_err: ERR=1 ERR_CODE=%0d, required no error", bus.ERR_CODE);
        end else begin
          e = err_q.pop_front();
          if (bus.ERR_CODE !== e) begin
            n_fail++;
            $display("FAIL err_code: got %0d, required %0d", bus.ERR_CODE, e);
          end
        end
      end
      if (bus.CMD_VALID === 1'b1 && !prev_vld) begin
        n_checks++;
        if (cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_cmd: OP_A=%0d OP_B=%0d OPCODE=%b, required no command",
                   bus.OP_A, bus.OP_B, bus.OPCODE);
        end else begin
          c = cmd_q.pop_front();
          if (bus.OP_A !== c.a || bus.OP_B !== c.b || bus.OPCODE !== c.op) begin
            n_fail++;
            $display("FAIL cmd: got OP_A=%0d OP_B=%0d OPCODE=%b, required OP_A=%0d OP_B=%0d OPCODE=%b",
                     bus.OP_A, bus.OP_B, bus.OPCODE, c.a, c.b, c.op);
          end
        end
      end
      prev_vld = (bus.CMD_VALID === 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    n_checks++;
    if (bus.STATE !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required 0", bus.STATE);
    end
    n_checks++;
    if (bus.CMD_VALID !== 1'b0 || bus.ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: CMD_VALID=%b ERR=%b, required 0 0", bus.CMD_VALID, bus.ERR);
    end
    n_checks++;
    if (bus.OP_A !== 8'd0 || bus.OP_B !== 8'd0 || bus.OPCODE !== 6'd0 || bus.ERR_CODE !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_regs: OP_A=%0d OP_B=%0d OPCODE=%b ERR_CODE=%0d, required all 0",
               bus.OP_A, bus.OP_B, bus.OPCODE, bus.ERR_CODE);
    end
    n_checks++;
    if (bus.RD_FIFO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd: RD_FIFO=%b, required 0", bus.RD_FIFO);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_basic();
    bus.CMD_READY = 1'b1;
    rd_count = 0;
    send_line("7+3");
    expect_cmd(8'd7, 8'd3, 6'b100000);
    wait_idle("basic");
    n_checks++;
    if (rd_count !== 4) begin
      n_fail++;
      $display("FAIL basic_rd_count: got %0d pops, required 4", rd_count);
    end
    send_line("6>2");
    expect_cmd(8'd6, 8'd2, 6'b000010);
    wait_idle("srl");
  endtask

  task automatic test_overflow();
    rd_count = 0;
    send_line("255-1");
    expect_cmd(8'd255, 8'd1, 6'b100010);
    send_line("256+1");
    err_q.push_back(2'd2);
    wait_idle("overflow");
    n_checks++;
    if (rd_count !== 12) begin
      n_fail++;
      $display("FAIL overflow_rd_count: got %0d pops, required 12", rd_count);
    end
  endtask

  task automatic test_too_long();
    send_line("1234+1");
    err_q.push_back(2'd1);
    send_line(" 12 & 5");
    push_byte(8'h0A);
    expect_cmd(8'd12, 8'd5, 6'b100100);
    wait_idle("too_long");
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    bus.CMD_READY = 1'b0;
    send_line("9|2");
    send_line("4~1");
    expect_cmd(8'd9, 8'd2, 6'b100101);
    expect_cmd(8'd4, 8'd1, 6'b100111);
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (bus.CMD_VALID === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL hold_valid_timeout: CMD_VALID=%b after 100 cycles, required 1", bus.CMD_VALID);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.CMD_VALID !== 1'b1 || bus.RD_FIFO !== 1'b0 || bus.STATE !== 3'd2 ||
          bus.OP_A !== 8'd9 || bus.OP_B !== 8'd2 || bus.OPCODE !== 6'b100101) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d VALID=%b RD=%b STATE=%0d A=%0d B=%0d OPC=%b, required 1 0 2 9 2 100101",
                 k, bus.CMD_VALID, bus.RD_FIFO, bus.STATE, bus.OP_A, bus.OP_B, bus.OPCODE);
      end
    end
    bus.CMD_READY = 1'b1;
    wait_idle("back_to_back");
  endtask

  task automatic test_errors();
    bit seen = 1'b0;
    send_line("7+");
    err_q.push_back(2'd3);
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (bus.ERR === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || bus.STATE !== 3'd0) begin
      n_fail++;
      $display("FAIL cr_err_state: ERR seen=%0d STATE=%0d, required seen=1 STATE=0", seen, bus.STATE);
    end
    wait_idle("cr_err");
    send_line("8]1");
    expect_cmd(8'd8, 8'd1, 6'b000011);
    send_line("7x3");
    err_q.push_back(2'd0);
    wait_idle("bad_char");
  endtask

  task automatic test_reset_midline();
    send_line("+");
    err_q.push_back(2'd3);
    wait_idle("pre_reset");
    send("12");
    wait_idle("partial");
    @(negedge CLK);
    RESET = 1'b0;
    send_line("5^3");
    expect_cmd(8'd5, 8'd3, 6'b100110);
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++;
      if (bus.RD_FIFO !== 1'b0 || bus.CMD_VALID !== 1'b0 || bus.ERR !== 1'b0 ||
          bus.STATE !== 3'd0 || bus.OP_A !== 8'd0 || bus.OP_B !== 8'd0 ||
          bus.OPCODE !== 6'd0 || bus.ERR_CODE !== 2'd0) begin
        n_fail++;
        $display("FAIL midline_reset: cycle %0d RD=%b VALID=%b ERR=%b STATE=%0d A=%0d B=%0d OPC=%b CODE=%0d, required all 0",
                 k, bus.RD_FIFO, bus.CMD_VALID, bus.ERR, bus.STATE, bus.OP_A, bus.OP_B,
                 bus.OPCODE, bus.ERR_CODE);
      end
      @(negedge CLK);
    end
    RESET = 1'b1;
    wait_idle("after_reset");
  endtask

  initial begin
    bus.FIFO_EMPTY = 1'b1;
    bus.RX_DATA    = 8'h00;
    bus.CMD_READY  = 1'b0;
    fork
      pop_loop();
      fifo_loop();
      monitor();
    join_none
    test_reset();
    test_basic();
    test_overflow();
    test_too_long();
    test_back_to_back();
    test_errors();
    test_reset_midline();
    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
